// File: rtl/note_divider.sv
// ----------------------------------------------------------------------------
// note_divider
//
// Programmable square-wave tone divider. Divides clock_in by a run-time
// divisor with a selectable duty cycle, emits a one-cycle tick per completed
// period, and only switches divisor or duty at period boundaries, so the
// output never produces a runt pulse.
//
// Parameters:
//   WIDTH        width of the period counter and divisor
//   DEFAULT_DIV  divisor in use after reset (must be >= 2)
//
// Ports:
//   clock_in    in   system clock, all state moves on its rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   run the divider; low holds it idle at count 0
//   div_in      in   candidate divisor
//   div_load    in   one-cycle strobe capturing div_in
//   duty_sel    in   00=50%, 01=25%, 10=12.5%, 11=75%
//   clock_out   out  registered divided square wave
//   tick        out  registered one-cycle pulse per completed period
//   pending     out  an accepted divisor waits for the next boundary
//   load_err    out  one-cycle pulse after a rejected load (div_in < 2)
//   active_div  out  divisor currently in use
// ----------------------------------------------------------------------------
module note_divider #(
    parameter int          WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 24000000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic [1:0]       duty_sel,
    output logic             clock_out,
    output logic             tick,
    output logic             pending,
    output logic             load_err,
    output logic [WIDTH-1:0] active_div
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    // Number of high cycles per period for divisor d and duty code sel.
    // Truncating shifts; a result of zero yields a constant-low output.
    function automatic logic [WIDTH-1:0] high_len(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       sel
    );
        logic [WIDTH-1:0] h;
        case (sel)
            2'b00:   h = d >> 1;
            2'b01:   h = d >> 2;
            2'b10:   h = d >> 3;
            default: h = d - (d >> 2);
        endcase
        return h;
    endfunction

    logic [WIDTH-1:0] counter_q,     counter_d;
    logic [WIDTH-1:0] active_div_q,  active_div_d;
    logic [WIDTH-1:0] pending_div_q, pending_div_d;
    logic             pending_q,     pending_d;
    logic [1:0]       duty_q,        duty_d;
    logic             clock_out_q,   clock_out_d;
    logic             tick_q,        tick_d;
    logic             load_err_q,    load_err_d;

    logic [WIDTH-1:0] high_cycles;
    logic             wrap;
    logic             load_ok;
    logic             load_bad;

    assign high_cycles = high_len(active_div_q, duty_q);
    // The counter never exceeds active_div_q-1 because the divisor only
    // changes when the counter is being cleared.
    assign wrap        = (counter_q == (active_div_q - ONE));
    assign load_ok     = div_load && (div_in >= TWO);
    assign load_bad    = div_load && (div_in <  TWO);

    // ---- next-state: counter, waveform, boundary and load handling ----
    always_comb begin
        counter_d     = counter_q;
        active_div_d  = active_div_q;
        pending_div_d = pending_div_q;
        pending_d     = pending_q;
        duty_d        = duty_q;
        clock_out_d   = clock_out_q;
        tick_d        = 1'b0;
        load_err_d    = load_bad;

        if (enable) begin
            counter_d   = wrap ? '0 : counter_q + ONE;
            clock_out_d = (counter_q < high_cycles);
            tick_d      = wrap;
            if (wrap) begin
                duty_d = duty_sel;
                if (pending_q) begin
                    active_div_d = pending_div_q;
                    pending_d    = 1'b0;
                end
            end
        end else begin
            // Idle: park at count 0 and take any waiting divisor/duty now,
            // so a re-enable always starts a clean full period.
            counter_d   = '0;
            clock_out_d = 1'b0;
            duty_d      = duty_sel;
            if (pending_q) begin
                active_div_d = pending_div_q;
                pending_d    = 1'b0;
            end
        end

        // A load coinciding with a boundary is applied after the boundary
        // has consumed the previously pending value, so it stays pending.
        if (load_ok) begin
            pending_div_d = div_in;
            pending_d     = 1'b1;
        end
    end

    // ---- state registers ----
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            counter_q     <= '0;
            active_div_q  <= DEF_DIV;
            pending_div_q <= DEF_DIV;
            pending_q     <= 1'b0;
            duty_q        <= 2'b00;
            clock_out_q   <= 1'b0;
            tick_q        <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            counter_q     <= counter_d;
            active_div_q  <= active_div_d;
            pending_div_q <= pending_div_d;
            pending_q     <= pending_d;
            duty_q        <= duty_d;
            clock_out_q   <= clock_out_d;
            tick_q        <= tick_d;
            load_err_q    <= load_err_d;
        end
    end

    assign clock_out  = clock_out_q;
    assign tick       = tick_q;
    assign pending    = pending_q;
    assign load_err   = load_err_q;
    assign active_div = active_div_q;

endmodule

// File: tb/tb_note_divider.sv
module tb_note_divider;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic       ld;
    logic [1:0] duty;
    logic       clk_out;
    logic       tk;
    logic       pend;
    logic       err;
    logic [7:0] act;

    int total = 0;
    int bad   = 0;

    note_divider #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .enable     (en),
        .div_in     (din),
        .div_load   (ld),
        .duty_sel   (duty),
        .clock_out  (clk_out),
        .tick       (tk),
        .pending    (pend),
        .load_err   (err),
        .active_div (act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] din;
        logic       ld;
        logic [1:0] duty;
        logic       e_clk;
        logic       e_tick;
        logic       e_pend;
        logic       e_err;
        logic [7:0] e_act;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input int e, input int d, input int l, input int ds,
                                input int c, input int t, input int p, input int er,
                                input int a);
        vec_t v;
        v.en     = e[0];
        v.din    = d[7:0];
        v.ld     = l[0];
        v.duty   = ds[1:0];
        v.e_clk  = c[0];
        v.e_tick = t[0];
        v.e_pend = p[0];
        v.e_err  = er[0];
        v.e_act  = a[7:0];
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input int row, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s row=%0d got=%0d want=%0d", nm, row, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input int row, input int c, input int t,
                             input int p, input int er, input int a);
        check({tag, ".clock_out"},  row, int'(clk_out), c);
        check({tag, ".tick"},       row, int'(tk),      t);
        check({tag, ".pending"},    row, int'(pend),    p);
        check({tag, ".load_err"},   row, int'(err),     er);
        check({tag, ".active_div"}, row, int'(act),     a);
    endtask

    initial begin
        // Row n corresponds to the n-th enabled/clocked edge after reset.
        // Edges 1-20: D=10, 50% duty: 5 high / 5 low, tick on edges 10, 20.
        for (int k = 1; k <= 20; k++)
            add(1, 0, 0, 0, (((k - 1) % 10) < 5) ? 1 : 0, (((k - 1) % 10) == 9) ? 1 : 0, 0, 0, 10);
        // Edges 21-23: counts 0..2.
        for (int j = 0; j < 3; j++) add(1, 0, 0, 0, 1, 0, 0, 0, 10);
        // Edge 24: load 4 at count 3.
        add(1, 4, 1, 0, 1, 0, 1, 0, 10);
        add(1, 0, 0, 0, 1, 0, 1, 0, 10);                // count 4
        for (int j = 0; j < 4; j++) add(1, 0, 0, 0, 0, 0, 1, 0, 10);  // counts 5..8
        // Edge 30: wrap applies 4 while a new load of 6 becomes pending.
        add(1, 6, 1, 0, 0, 1, 1, 0, 4);
        // Edges 31-34: one D=4 period, 2 high / 2 low, wrap applies 6.
        add(1, 0, 0, 0, 1, 0, 1, 0, 4);
        add(1, 0, 0, 0, 1, 0, 1, 0, 4);
        add(1, 0, 0, 0, 0, 0, 1, 0, 4);
        add(1, 0, 0, 0, 0, 1, 0, 0, 6);
        // Edges 35-40: D=6, 3 high / 3 low.
        for (int j = 0; j < 6; j++) add(1, 0, 0, 0, (j < 3) ? 1 : 0, (j == 5) ? 1 : 0, 0, 0, 6);
        // Edge 41: rejected load of 1.
        add(1, 1, 1, 0, 1, 0, 0, 1, 6);
        // Edge 42: accept load of 8.
        add(1, 8, 1, 0, 1, 0, 1, 0, 6);
        // Edges 43-45: duty_sel=01 mid-period; count 2 still uses H=3.
        add(1, 0, 0, 1, 1, 0, 1, 0, 6);
        add(1, 0, 0, 1, 0, 0, 1, 0, 6);
        add(1, 0, 0, 1, 0, 0, 1, 0, 6);
        // Edge 46: wrap applies D=8 and duty 01.
        add(1, 0, 0, 1, 0, 1, 0, 0, 8);
        // Edges 47-54: 25% -> 2 high / 6 low; duty 11 latched at edge 54.
        for (int j = 0; j < 7; j++) add(1, 0, 0, 1, (j < 2) ? 1 : 0, 0, 0, 0, 8);
        add(1, 0, 0, 3, 0, 1, 0, 0, 8);
        // Edges 55-62: 75% -> 6 high / 2 low; duty 10 latched at edge 62.
        for (int j = 0; j < 7; j++) add(1, 0, 0, 3, (j < 6) ? 1 : 0, 0, 0, 0, 8);
        add(1, 0, 0, 2, 0, 1, 0, 0, 8);
        // Edges 63-70: 12.5% -> 1 high / 7 low; duty 11 latched at edge 70.
        for (int j = 0; j < 7; j++) add(1, 0, 0, 2, (j < 1) ? 1 : 0, 0, 0, 0, 8);
        add(1, 0, 0, 3, 0, 1, 0, 0, 8);
        // Edges 71-76: 75% again, load 10 at count 4.
        for (int j = 0; j < 4; j++) add(1, 0, 0, 3, 1, 0, 0, 0, 8);
        add(1, 10, 1, 3, 1, 0, 1, 0, 8);
        add(1, 0, 0, 3, 1, 0, 1, 0, 8);
        // Edges 77-78: disabled at count 6; pending 10 applied; no tick at
        // the edge where count 7 would have wrapped.
        add(0, 0, 0, 3, 0, 0, 0, 0, 10);
        add(0, 0, 0, 3, 0, 0, 0, 0, 10);
        // Edges 79-88: re-enabled full period from 0, D=10 at 75% -> 8/2.
        for (int j = 0; j < 10; j++) add(1, 0, 0, 3, (j < 8) ? 1 : 0, (j == 9) ? 1 : 0, 0, 0, 10);
        // Edge 89: load 5, to be discarded by the reset below.
        add(1, 5, 1, 3, 1, 0, 1, 0, 10);

        rst_n = 1'b0;
        en    = 1'b0;
        din   = 8'd0;
        ld    = 1'b0;
        duty  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 10);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            en   = vq[i].en;
            din  = vq[i].din;
            ld   = vq[i].ld;
            duty = vq[i].duty;
            @(posedge clk);
            #1;
            check_all("vec", i + 1, int'(vq[i].e_clk), int'(vq[i].e_tick),
                      int'(vq[i].e_pend), int'(vq[i].e_err), int'(vq[i].e_act));
        end

        // Asynchronous reset mid-run: outputs drop without waiting for a clock.
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 10);
        @(negedge clk);
        en   = 1'b1;
        ld   = 1'b0;
        din  = 8'd0;
        duty = 2'b00;
        @(posedge clk);
        #1;
        check_all("hold_rst", 0, 0, 0, 0, 0, 10);
        @(negedge clk);
        rst_n = 1'b1;
        // Restart: D=10, 50%; the discarded 5 never takes effect.
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            check_all("post_rst", j + 1, (j < 5) ? 1 : 0, (j == 9) ? 1 : 0, 0, 0, 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_divider.md
# note_divider

Programmable square-wave tone divider for the musical-notes design: divides `clock_in` by a run-time divisor, with selectable duty cycle, a per-period tick, and glitch-free divisor changes applied only at period boundaries. It is the parametrised successor to the fixed-divisor 1 Hz timebase. It drives note outputs (buzzer/speaker pin) and note-duration sequencing (via `tick`) from one instance type.

## Interface
Parameters:
- `WIDTH`, 28: width of the counter and divisor.
- `DEFAULT_DIV`, 24000000: divisor loaded at reset. Must be ≥ 2.

Ports:
- `clock_in` in 1: system clock. All state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run the divider. When low, the divider is held idle.
- `div_in` in WIDTH: new divisor value.
- `div_load` in 1: one-cycle strobe that captures `div_in`.
- `duty_sel` in 2: duty-cycle select. 00 = 50%, 01 = 25%, 10 = 12.5%, 11 = 75%.
- `clock_out` out 1: divided square wave, registered.
- `tick` out 1: one-cycle pulse per completed period, registered.
- `pending` out 1: a loaded divisor is waiting for the next boundary.
- `load_err` out 1: one-cycle pulse when a load is rejected.
- `active_div` out WIDTH: divisor currently in use.

## Operation
- **Internal state**
  - `counter` (WIDTH bits) and `pending_div`.
  - `duty_q`: the latched `duty_sel`.
- **High length `H`**, computed from `active_div` (D) and `duty_q`:
  - 00: D>>1
  - 01: D>>2
  - 10: D>>3
  - 11: D − (D>>2)
  - Integer truncation. H = 0 (possible for D < 8 with duty 10) gives a constant-low `clock_out`.
- **Enabled edge**
  - If `counter == D−1`, this is a wrap: `counter` ← 0.
  - Otherwise `counter` ← `counter` + 1.
  - `clock_out` ← (pre-edge `counter` < H).
  - `tick` ← 1 on a wrap, else 0.
- **Boundary (wrap) actions**
  - `duty_q` ← `duty_sel`.
  - If `pending` is set, then `active_div` ← `pending_div` and `pending` ← 0.
- **Load**
  - When `div_load` = 1 and `div_in` ≥ 2: `pending_div` ← `div_in` and `pending` ← 1.
  - A load arriving while a load is already pending overwrites it; the last load wins.
  - A load in the same cycle as a wrap:
    - The wrap applies the old `pending_div`, if one was pending.
    - The new value becomes pending, and `pending` stays 1.
    - The new value takes effect at the following wrap.
- **Rejected load**
  - When `div_load` = 1 and `div_in` < 2: `load_err` ← 1 for one cycle.
  - `pending`, `pending_div` and `active_div` are unchanged.
- **Disabled edge** (`enable` = 0)
  - `counter` ← 0, `clock_out` ← 0, `tick` ← 0.
  - `duty_q` ← `duty_sel`.
  - If `pending` is set (pre-edge), then `active_div` ← `pending_div` and `pending` ← 0.
  - A load on a disabled edge sets `pending`. It is applied on the next disabled edge or the next wrap.
- **Arithmetic**
  - The counter never exceeds D−1.
  - Comparisons are unsigned at WIDTH bits; there is no overflow path.

## Timing
- **Reset values:**
  - `counter` = 0
  - `active_div` = `pending_div` = DEFAULT_DIV
  - `duty_q` = 00
  - `pending` = 0
  - `clock_out` = 0, `tick` = 0, `load_err` = 0
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronously), and any pending load is discarded.
- **Enable latency:**
  - `clock_out` goes high at the first enabled edge.
  - The first `tick` is asserted after the D-th enabled edge.
  - Thereafter, the period is exactly D cycles with `clock_out` high for H cycles.
- **Disable latency:** `clock_out` and `tick` are low after the first disabled edge. Re-enabling restarts a full period from count 0.
- **Status signals:**
  - `pending` rises one cycle after an accepted `div_load`.
  - `load_err` pulses one cycle after a rejected `div_load`.
- **Divisor change:** the new `active_div` is visible the cycle after the wrap that consumes it, and the first new-length period starts at that wrap.
- **No glitches:** `clock_out` is a flop output, with no runt pulses on divisor or duty changes.

## Test plan
- **Reset:** use WIDTH=8, DEFAULT_DIV=10.
  - Assert `reset_n`=0 mid-run → all outputs are at their reset values at once, with `active_div`=10 and `pending`=0.
- **Basic divide:**
  - `enable`=1, duty 00, D=10 → `clock_out` is 5 high / 5 low repeating.
  - `tick` is a single-cycle pulse every 10 cycles; the first pulse is after the 10th enabled edge.
- **Boundary load:**
  - Load `div_in`=4 when `counter`=3 → `pending`=1 next cycle, and the 10-cycle period completes.
  - Then `active_div`=4, `pending`=0, and `clock_out` runs 2/2.
  - A second load of 6 in the wrap cycle → 4 is applied at that wrap, 6 is applied at the next wrap.
- **Rejected load:** `div_in`=1 with `div_load` → `load_err` pulses 1 cycle, and `pending` and `active_div` are unchanged.
- **Duty modes:** D=8.
  - duty 01 → 2 high / 6 low.
  - duty 11 → 6 high / 2 low.
  - duty 10 → 1 high / 7 low.
  - Changing `duty_sel` mid-period takes effect only from the next period.
- **Disable mid-period:**
  - Drop `enable` at `counter`=6 → `clock_out`=0 and `tick`=0 next cycle.
  - A pending divisor is applied while disabled.
  - Re-enable → a full new period starts from count 0.
